ring_counter_param: RTL and testbench

- Parametrised successor to the team's fixed 4-bit ring counter.
- Generalised in width; selectable at elaboration between one-hot ring and Johnson (twisted-ring) sequencing.
- Adds count enable, bidirectional stepping, parallel load with legality check, illegal-state self-correction, sequence-position output and a wrap pulse.
- Used as a one-hot phase/slot sequencer and timing-strobe generator.

---
 rtl/ring_counter_param.sv | 123 ++++++++++++
 tb/tb_ring_counter_param.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_param.sv
// Parametrised one-hot ring / Johnson sequencer with load, self-correction, position and wrap outputs.
// All outputs registered, one-cycle latency from inputs; no backpressure, en simply gates stepping.
module ring_counter_param #(
    parameter int WIDTH = 4,
    parameter int MODE  = 0,
    parameter int POS_W = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [POS_W-1:0] pos,
    output logic             wrap,
    output logic             err
);
    localparam int               N       = (MODE == 1) ? 2*WIDTH : WIDTH;
    localparam logic [POS_W-1:0] LAST    = POS_W'(N-1);
    localparam logic [WIDTH-1:0] RST_PAT = (MODE == 1) ? '0 : {1'b1, {(WIDTH-1){1'b0}}};

    // Johnson-legal means a contiguous run of ones touching either end (or all zeros).
    function automatic logic f_legal(input logic [WIDTH-1:0] v);
        logic             ok;
        logic [WIDTH-1:0] lo_run;
        logic [WIDTH-1:0] hi_run;
        ok = 1'b0;
        if (MODE == 0) begin
            ok = ($countones(v) == 1);
        end else begin
            for (int k = 0; k <= WIDTH; k++) begin
                lo_run = ~({WIDTH{1'b1}} << k);
                hi_run = ~({WIDTH{1'b1}} >> k);
                if (v == lo_run || v == hi_run) ok = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic logic [POS_W-1:0] f_pos(input logic [WIDTH-1:0] v);
        int set_idx;
        int ones;
        logic [POS_W-1:0] p;
        set_idx = 0;
        ones    = $countones(v);
        p       = '0;
        if (MODE == 0) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (v[k]) set_idx = k;
            end
            p = POS_W'(WIDTH - 1 - set_idx);
        end else if (v == '0) begin
            p = '0;
        end else if (v[WIDTH-1]) begin
            p = POS_W'(ones);
        end else begin
            p = POS_W'(2*WIDTH - ones);
        end
        return p;
    endfunction

    logic [WIDTH-1:0] r_q;
    logic [POS_W-1:0] r_pos;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_q_fwd;
    logic [WIDTH-1:0] w_q_rev;
    logic             w_cur_legal;
    logic             w_load_legal;
    logic [POS_W-1:0] w_load_pos;

    assign w_q_fwd      = {(MODE == 1) ? ~r_q[0] : r_q[0], r_q[WIDTH-1:1]};
    assign w_q_rev      = {r_q[WIDTH-2:0], (MODE == 1) ? ~r_q[WIDTH-1] : r_q[WIDTH-1]};
    assign w_cur_legal  = f_legal(r_q);
    assign w_load_legal = f_legal(load_val);
    assign w_load_pos   = f_pos(load_val);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q    <= RST_PAT;
            r_pos  <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else if (load) begin
            r_wrap <= 1'b0;
            if (w_load_legal) begin
                r_q   <= load_val;
                r_pos <= w_load_pos;
                r_err <= 1'b0;
            end else begin
                r_q   <= RST_PAT;
                r_pos <= '0;
                r_err <= 1'b1;
            end
        end else if (!w_cur_legal) begin
            r_q    <= RST_PAT;
            r_pos  <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b1;
        end else if (en) begin
            r_err <= 1'b0;
            if (dir) begin
                r_q    <= w_q_rev;
                r_pos  <= (r_pos == '0) ? LAST : r_pos - 1'b1;
                r_wrap <= (r_pos == '0);
            end else begin
                r_q    <= w_q_fwd;
                r_pos  <= (r_pos == LAST) ? '0 : r_pos + 1'b1;
                r_wrap <= (r_pos == LAST);
            end
        end else begin
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end
    end

    assign q    = r_q;
    assign pos  = r_pos;
    assign wrap = r_wrap;
    assign err  = r_err;
endmodule

// File: tb/tb_ring_counter_param.sv
// Bench for ring_counter_param: five configurations checked against a sequence-table model.
module tb_ring_counter_param;
    logic       clk;
    logic [4:0] rst_a, en_a, dir_a, load_a;
    logic [7:0] lv_a [5];

    logic [3:0] q0, q1;
    logic [2:0] p0, p1;
    logic [7:0] q2;
    logic [3:0] p2;
    logic [1:0] q3, q4, p3, p4;
    logic [4:0] wr_o, er_o;

    int         W_A [5] = '{4, 4, 8, 2, 2};
    int         M_A [5] = '{0, 1, 1, 1, 0};

    logic [7:0] m_q [5];
    int         m_p [5];
    logic [4:0] m_wrap, m_err;

    int errors = 0;
    int checks = 0;

    ring_counter_param #(.WIDTH(4), .MODE(0)) u_r4 (.clk(clk), .rst(rst_a[0]), .en(en_a[0]), .dir(dir_a[0]),
        .load(load_a[0]), .load_val(lv_a[0][3:0]), .q(q0), .pos(p0), .wrap(wr_o[0]), .err(er_o[0]));
    ring_counter_param #(.WIDTH(4), .MODE(1)) u_j4 (.clk(clk), .rst(rst_a[1]), .en(en_a[1]), .dir(dir_a[1]),
        .load(load_a[1]), .load_val(lv_a[1][3:0]), .q(q1), .pos(p1), .wrap(wr_o[1]), .err(er_o[1]));
    ring_counter_param #(.WIDTH(8), .MODE(1)) u_j8 (.clk(clk), .rst(rst_a[2]), .en(en_a[2]), .dir(dir_a[2]),
        .load(load_a[2]), .load_val(lv_a[2]), .q(q2), .pos(p2), .wrap(wr_o[2]), .err(er_o[2]));
    ring_counter_param #(.WIDTH(2), .MODE(1)) u_j2 (.clk(clk), .rst(rst_a[3]), .en(en_a[3]), .dir(dir_a[3]),
        .load(load_a[3]), .load_val(lv_a[3][1:0]), .q(q3), .pos(p3), .wrap(wr_o[3]), .err(er_o[3]));
    ring_counter_param #(.WIDTH(2), .MODE(0)) u_r2 (.clk(clk), .rst(rst_a[4]), .en(en_a[4]), .dir(dir_a[4]),
        .load(load_a[4]), .load_val(lv_a[4][1:0]), .q(q4), .pos(p4), .wrap(wr_o[4]), .err(er_o[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs_q(input int d);
        case (d)
            0: return {4'b0, q0};
            1: return {4'b0, q1};
            2: return q2;
            3: return {6'b0, q3};
            default: return {6'b0, q4};
        endcase
    endfunction

    function automatic int obs_pos(input int d);
        case (d)
            0: return int'(p0);
            1: return int'(p1);
            2: return int'(p2);
            3: return int'(p3);
            default: return int'(p4);
        endcase
    endfunction

    // Sequence table: entry p is the p-th pattern reached by forward steps from the reset pattern.
    function automatic int seq_n(input int w, input int m);
        return (m == 1) ? 2*w : w;
    endfunction

    function automatic logic [7:0] pat(input int w, input int m, input int p);
        logic [7:0] full;
        full = 8'((1 << w) - 1);
        if (m == 0) return 8'(1 << (w - 1 - p));
        if (p <= w) return full & ~8'((1 << (w - p)) - 1);
        return 8'((1 << (2*w - p)) - 1);
    endfunction

    function automatic int idx_of(input int w, input int m, input logic [7:0] v);
        for (int p = 0; p < seq_n(w, m); p++) begin
            if (pat(w, m, p) == v) return p;
        end
        return -1;
    endfunction

    task automatic model_update(input int d);
        int w, m, n, i, cur;
        w = W_A[d];
        m = M_A[d];
        n = seq_n(w, m);
        cur = idx_of(w, m, m_q[d]);
        m_wrap[d] = 1'b0;
        m_err[d]  = 1'b0;
        if (!rst_a[d]) begin
            m_p[d] = 0;
        end else if (load_a[d]) begin
            i = idx_of(w, m, lv_a[d] & 8'((1 << w) - 1));
            if (i >= 0) m_p[d] = i;
            else begin
                m_p[d] = 0;
                m_err[d] = 1'b1;
            end
        end else if (cur < 0) begin
            m_p[d] = 0;
            m_err[d] = 1'b1;
        end else if (en_a[d]) begin
            if (dir_a[d]) begin
                m_wrap[d] = (cur == 0);
                m_p[d] = (cur + n - 1) % n;
            end else begin
                m_wrap[d] = (cur == n - 1);
                m_p[d] = (cur + 1) % n;
            end
        end else begin
            m_p[d] = cur;
        end
        m_q[d] = pat(w, m, m_p[d]);
    endtask

    task automatic drive(input int d, input logic r, input logic e, input logic dr,
                         input logic ld, input logic [7:0] lv);
        for (int k = 0; k < 5; k++) begin
            rst_a[k] = 1'b1; en_a[k] = 1'b0; dir_a[k] = 1'b0; load_a[k] = 1'b0; lv_a[k] = 8'h00;
        end
        rst_a[d] = r; en_a[d] = e; dir_a[d] = dr; load_a[d] = ld; lv_a[d] = lv;
        @(posedge clk);
        for (int k = 0; k < 5; k++) model_update(k);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            for (int d = 0; d < 5; d++) begin
                rst_a[d] = 1'b0; en_a[d] = 1'($urandom); dir_a[d] = 1'($urandom);
                load_a[d] = 1'($urandom); lv_a[d] = 8'($urandom);
            end
            @(posedge clk);
            for (int d = 0; d < 5; d++) model_update(d);
            #1;
            for (int d = 0; d < 5; d++) begin
                checks++;
                if (obs_q(d) !== m_q[d] || obs_pos(d) !== 0 || wr_o[d] !== 1'b0 || er_o[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset inst%0d: got q=%b pos=%0d wrap=%b err=%b, want q=%b pos=0 wrap=0 err=0",
                             d, obs_q(d), obs_pos(d), wr_o[d], er_o[d], m_q[d]);
                end
            end
        end
    endtask

    task automatic test_ring_steps();
        // forward x5, hold x3, load 1000, reverse x2, then dir toggling x6
        for (int i = 0; i < 17; i++) begin
            if (i < 5)       drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            else if (i < 8)  drive(0, 1'b1, 1'b0, 1'($urandom), 1'b0, 8'h00);
            else if (i == 8) drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 8'b1000);
            else if (i < 11) drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            else             drive(0, 1'b1, 1'b1, 1'(i), 1'b0, 8'h00);
            checks++;
            if (obs_q(0) !== m_q[0] || obs_pos(0) !== m_p[0] || wr_o[0] !== m_wrap[0] || er_o[0] !== m_err[0]) begin
                errors++;
                $display("FAIL ring_steps step%0d: got q=%b pos=%0d wrap=%b err=%b, want q=%b pos=%0d wrap=%b err=%b",
                         i, obs_q(0), obs_pos(0), wr_o[0], er_o[0], m_q[0], m_p[0], m_wrap[0], m_err[0]);
            end
        end
    endtask

    task automatic test_johnson_fwd();
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            drive(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_q(1) !== m_q[1] || obs_pos(1) !== m_p[1] || wr_o[1] !== m_wrap[1] || er_o[1] !== m_err[1]) begin
                errors++;
                $display("FAIL johnson_fwd step%0d: got q=%b pos=%0d wrap=%b err=%b, want q=%b pos=%0d wrap=%b err=%b",
                         i, obs_q(1), obs_pos(1), wr_o[1], er_o[1], m_q[1], m_p[1], m_wrap[1], m_err[1]);
            end
        end
    endtask

    task automatic test_load();
        int         d_t  [6] = '{0, 0, 0, 1, 1, 1};
        logic [7:0] lv_t [6] = '{8'b0010, 8'b0110, 8'b0001, 8'b0011, 8'b0101, 8'b0011};
        logic       en_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(d_t[i], 1'b1, en_t[i], 1'($urandom), 1'b1, lv_t[i]);
            checks++;
            if (obs_q(d_t[i]) !== m_q[d_t[i]] || obs_pos(d_t[i]) !== m_p[d_t[i]] ||
                wr_o[d_t[i]] !== m_wrap[d_t[i]] || er_o[d_t[i]] !== m_err[d_t[i]]) begin
                errors++;
                $display("FAIL load case%0d: got q=%b pos=%0d wrap=%b err=%b, want q=%b pos=%0d wrap=%b err=%b",
                         i, obs_q(d_t[i]), obs_pos(d_t[i]), wr_o[d_t[i]], er_o[d_t[i]],
                         m_q[d_t[i]], m_p[d_t[i]], m_wrap[d_t[i]], m_err[d_t[i]]);
            end
        end
    endtask

    task automatic test_recovery();
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            if (d == 0) force u_r4.r_q = 4'b1010;
            else        force u_j4.r_q = 4'b1001;
            #1;
            if (d == 0) release u_r4.r_q;
            else        release u_j4.r_q;
            m_q[d] = (d == 0) ? 8'b1010 : 8'b1001;
            for (int i = 0; i < 2; i++) begin
                drive(d, 1'b1, 1'($urandom), 1'b0, 1'b0, 8'h00);
                checks++;
                if (obs_q(d) !== m_q[d] || obs_pos(d) !== m_p[d] || wr_o[d] !== m_wrap[d] || er_o[d] !== m_err[d]) begin
                    errors++;
                    $display("FAIL recovery inst%0d cyc%0d: got q=%b pos=%0d wrap=%b err=%b, want q=%b pos=%0d wrap=%b err=%b",
                             d, i, obs_q(d), obs_pos(d), wr_o[d], er_o[d], m_q[d], m_p[d], m_wrap[d], m_err[d]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b0110);
        checks++;
        if (obs_q(0) !== 8'b1000 || obs_pos(0) !== 0 || wr_o[0] !== 1'b0 || er_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got q=%b pos=%0d wrap=%b err=%b, want q=00001000 pos=0 wrap=0 err=0",
                     obs_q(0), obs_pos(0), wr_o[0], er_o[0]);
        end
    endtask

    task automatic test_j8_cycles();
        int wraps;
        for (int r = 0; r < 2; r++) begin
            wraps = 0;
            for (int i = 0; i < 16; i++) begin
                drive(2, 1'b1, 1'b1, 1'(r), 1'b0, 8'h00);
                wraps += int'(wr_o[2]);
                checks++;
                if (obs_q(2) !== m_q[2] || obs_pos(2) !== m_p[2] || wr_o[2] !== m_wrap[2] || er_o[2] !== m_err[2]) begin
                    errors++;
                    $display("FAIL j8 dir%0d step%0d: got q=%b pos=%0d wrap=%b err=%b, want q=%b pos=%0d wrap=%b err=%b",
                             r, i, obs_q(2), obs_pos(2), wr_o[2], er_o[2], m_q[2], m_p[2], m_wrap[2], m_err[2]);
                end
            end
            checks++;
            if (wraps !== 1) begin
                errors++;
                $display("FAIL j8_wrap_count dir%0d: got %0d, want 1", r, wraps);
            end
        end
    endtask

    task automatic test_width2();
        for (int i = 0; i < 14; i++) begin
            int d;
            d = (i < 10) ? 3 : 4;
            drive(d, 1'b1, 1'b1, (i >= 6 && i < 10) || i >= 12, 1'b0, 8'h00);
            checks++;
            if (obs_q(d) !== m_q[d] || obs_pos(d) !== m_p[d] || wr_o[d] !== m_wrap[d] || er_o[d] !== m_err[d]) begin
                errors++;
                $display("FAIL width2 inst%0d step%0d: got q=%b pos=%0d wrap=%b err=%b, want q=%b pos=%0d wrap=%b err=%b",
                         d, i, obs_q(d), obs_pos(d), wr_o[d], er_o[d], m_q[d], m_p[d], m_wrap[d], m_err[d]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int d = 0; d < 5; d++) begin
                rst_a[d]  = ($urandom_range(0, 31) != 0);
                en_a[d]   = ($urandom_range(0, 3) != 0);
                dir_a[d]  = 1'($urandom);
                load_a[d] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 1) == 0)
                    lv_a[d] = pat(W_A[d], M_A[d], $urandom_range(0, seq_n(W_A[d], M_A[d]) - 1));
                else
                    lv_a[d] = 8'($urandom);
            end
            @(posedge clk);
            for (int d = 0; d < 5; d++) model_update(d);
            #1;
            for (int d = 0; d < 5; d++) begin
                checks++;
                if (obs_q(d) !== m_q[d] || obs_pos(d) !== m_p[d] || wr_o[d] !== m_wrap[d] || er_o[d] !== m_err[d]) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d: got q=%b pos=%0d wrap=%b err=%b, want q=%b pos=%0d wrap=%b err=%b",
                             d, c, obs_q(d), obs_pos(d), wr_o[d], er_o[d], m_q[d], m_p[d], m_wrap[d], m_err[d]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            rst_a[k] = 1'b0; en_a[k] = 1'b0; dir_a[k] = 1'b0; load_a[k] = 1'b0; lv_a[k] = 8'h00;
            m_q[k] = 8'h00; m_p[k] = 0;
        end
        m_wrap = '0;
        m_err  = '0;
        test_reset();
        test_ring_steps();
        test_johnson_fwd();
        test_load();
        test_recovery();
        test_reset_mid();
        test_j8_cycles();
        test_width2();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
